// File: rtl/comb_filter_ctrl.sv
// comb_filter_ctrl
// Sequencer for the I/Q comb filter stage. It brings the filter out of reset and
// drains its feedback history with zeros. It then feeds live data while the output
// stays on the raw path, and once the filter has settled it switches the output to
// the filtered path. Disable and restart requests abort or re-run the sequence.
// The raw path is delayed one clock so that both paths reach the output register
// with the same 2-clock latency, which keeps the switchover seamless.

module comb_filter_ctrl #(
   parameter int BIT_WIDTH     = 16,
   parameter int FLUSH_CYCLES  = 64,
   parameter int SETTLE_CYCLES = 256,
   parameter int CNT_WIDTH     = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable_req,
   input  logic                 restart,
   input  logic [BIT_WIDTH-1:0] i_raw,
   input  logic [BIT_WIDTH-1:0] q_raw,
   output logic                 filt_reset,
   output logic [BIT_WIDTH-1:0] filt_i_in,
   output logic [BIT_WIDTH-1:0] filt_q_in,
   input  logic [BIT_WIDTH-1:0] i_filt,
   input  logic [BIT_WIDTH-1:0] q_filt,
   output logic [BIT_WIDTH-1:0] i_out,
   output logic [BIT_WIDTH-1:0] q_out,
   output logic                 filt_active,
   output logic                 busy
);

   typedef enum logic [1:0] {
      BYPASS = 2'd0,
      FLUSH  = 2'd1,
      SETTLE = 2'd2,
      RUN    = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] FLUSH_LOAD  = CNT_WIDTH'(FLUSH_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

   state_t               state;
   state_t               state_next;
   logic [CNT_WIDTH-1:0] count;
   logic [CNT_WIDTH-1:0] count_next;
   logic [BIT_WIDTH-1:0] raw_i_d;
   logic [BIT_WIDTH-1:0] raw_q_d;

   // State and duration counter register; the counter is always reloaded on entry to a timed state
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= BYPASS;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Next-state logic: disable beats restart, restart beats the normal timed progression
   always_comb begin
      state_next = state;
      count_next = count;
      if (state == BYPASS) begin
         if (enable_req) begin
            state_next = FLUSH;
            count_next = FLUSH_LOAD;
         end
      end else if (!enable_req) begin
         state_next = BYPASS;
         count_next = '0;
      end else if (restart) begin
         state_next = FLUSH;
         count_next = FLUSH_LOAD;
      end else begin
         case (state)
            FLUSH: begin
               if (count == '0) begin
                  state_next = SETTLE;
                  count_next = SETTLE_LOAD;
               end else begin
                  count_next = count - CNT_ONE;
               end
            end
            SETTLE: begin
               if (count == '0) begin
                  state_next = RUN;
               end else begin
                  count_next = count - CNT_ONE;
               end
            end
            default: begin
               state_next = state;
            end
         endcase
      end
   end

   // Status and filter drive decoded from the state register; zeros are fed while flushing or held in reset
   always_comb begin
      filt_reset  = (state == BYPASS);
      busy        = (state == FLUSH) || (state == SETTLE);
      filt_active = (state == RUN);
      filt_i_in   = '0;
      filt_q_in   = '0;
      if ((state == SETTLE) || (state == RUN)) begin
         filt_i_in = i_raw;
         filt_q_in = q_raw;
      end
   end

   // Output path: raw samples get one delay stage to match the filter latency, then the selected path is registered
   always_ff @(posedge clock) begin
      if (reset) begin
         raw_i_d <= '0;
         raw_q_d <= '0;
         i_out   <= '0;
         q_out   <= '0;
      end else begin
         raw_i_d <= i_raw;
         raw_q_d <= q_raw;
         i_out   <= (state == RUN) ? i_filt : raw_i_d;
         q_out   <= (state == RUN) ? q_filt : raw_q_d;
      end
   end

endmodule

// File: tb/tb_comb_filter_ctrl.sv
// tb_comb_filter_ctrl
// Self-checking bench for comb_filter_ctrl with short flush/settle lengths.
// The external comb filter is stood in for by "previous raw sample + 0x100".
// The reference model tracks only whether a sequence is active and how many
// clocks have elapsed since it (re)started; the phase is derived from that.

module tb_comb_filter_ctrl;

   localparam int BW = 16;
   localparam int F  = 4;
   localparam int S  = 8;
   localparam logic [BW-1:0] OFFS = 16'h0100;

   logic          clock;
   logic          reset;
   logic          enable_req;
   logic          restart;
   logic [BW-1:0] i_raw;
   logic [BW-1:0] q_raw;
   logic          filt_reset;
   logic [BW-1:0] filt_i_in;
   logic [BW-1:0] filt_q_in;
   logic [BW-1:0] i_filt;
   logic [BW-1:0] q_filt;
   logic [BW-1:0] i_out;
   logic [BW-1:0] q_out;
   logic          filt_active;
   logic          busy;

   int checks;
   int errors;

   // Reference model state
   bit            m_active;
   int            m_t;
   logic [BW-1:0] m_raw_i;
   logic [BW-1:0] m_raw_q;
   logic [BW-1:0] m_out_i;
   logic [BW-1:0] m_out_q;
   logic [BW-1:0] prev_i;
   logic [BW-1:0] prev_q;

   comb_filter_ctrl #(
      .BIT_WIDTH    (BW),
      .FLUSH_CYCLES (F),
      .SETTLE_CYCLES(S),
      .CNT_WIDTH    (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable_req (enable_req),
      .restart    (restart),
      .i_raw      (i_raw),
      .q_raw      (q_raw),
      .filt_reset (filt_reset),
      .filt_i_in  (filt_i_in),
      .filt_q_in  (filt_q_in),
      .i_filt     (i_filt),
      .q_filt     (q_filt),
      .i_out      (i_out),
      .q_out      (q_out),
      .filt_active(filt_active),
      .busy       (busy)
   );

   // Free-running sample clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Phase from elapsed time: 0 bypass, 1 flush, 2 settle, 3 run
   function automatic int m_phase();
      if (!m_active) return 0;
      if (m_t < F) return 1;
      if (m_t < F + S) return 2;
      return 3;
   endfunction

   function automatic logic exp_busy();
      return (m_phase() == 1) || (m_phase() == 2);
   endfunction

   function automatic logic exp_active();
      return m_phase() == 3;
   endfunction

   function automatic logic exp_freset();
      return m_phase() == 0;
   endfunction

   function automatic logic [BW-1:0] exp_fin(input logic [BW-1:0] raw);
      return (m_phase() == 1) ? '0 : raw;
   endfunction

   // Apply one clock of stimulus, advance the model, and settle 1 time unit past the edge
   task automatic applyStimulus(input logic rst, input logic en, input logic rs,
                                input logic [BW-1:0] ri, input logic [BW-1:0] rq);
      int ph_old;
      reset      = rst;
      enable_req = en;
      restart    = rs;
      i_raw      = ri;
      q_raw      = rq;
      i_filt     = prev_i + OFFS;
      q_filt     = prev_q + OFFS;
      ph_old     = m_phase();
      if (rst) begin
         m_out_i = '0;
         m_out_q = '0;
         m_raw_i = '0;
         m_raw_q = '0;
         m_active = 1'b0;
         m_t      = 0;
      end else begin
         m_out_i = (ph_old == 3) ? i_filt : m_raw_i;
         m_out_q = (ph_old == 3) ? q_filt : m_raw_q;
         m_raw_i = ri;
         m_raw_q = rq;
         if (!m_active) begin
            if (en) begin
               m_active = 1'b1;
               m_t      = 0;
            end
         end else if (!en) begin
            m_active = 1'b0;
         end else if (rs) begin
            m_t = 0;
         end else if (m_t < F + S) begin
            m_t++;
         end
      end
      prev_i = ri;
      prev_q = rq;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
         checks++;
         if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
         checks++;
         if (filt_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_filt_reset got=%0b want=1", filt_reset); end
         checks++;
         if (filt_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_filt_active got=%0b want=0", filt_active); end
         checks++;
         if (i_out !== 16'h0 || q_out !== 16'h0) begin
            errors++; $display("[TB] FAIL reset_out got=%h/%h want=0000/0000", i_out, q_out);
         end
      end
   endtask

   task automatic test_bypass_latency();
      logic [BW-1:0] vals [5] = '{16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 16'h0f0f};
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, vals[k], ~vals[k]);
         checks++;
         if (filt_reset !== 1'b1) begin errors++; $display("[TB] FAIL bypass_filt_reset k=%0d got=%0b want=1", k, filt_reset); end
         if (k >= 1) begin
            checks++;
            if (i_out !== vals[k-1] || q_out !== ~vals[k-1]) begin
               errors++;
               $display("[TB] FAIL bypass_latency k=%0d got=%h/%h want=%h/%h", k, i_out, q_out, vals[k-1], ~vals[k-1]);
            end
         end
      end
   endtask

   task automatic test_startup();
      int busy_count = 0;
      int first_active = 0;
      logic [BW-1:0] ri;
      for (int s = 1; s <= 20; s++) begin
         ri = 16'($urandom);
         applyStimulus(1'b0, 1'b1, 1'b0, ri, 16'($urandom));
         checks++;
         if (busy !== exp_busy()) begin errors++; $display("[TB] FAIL startup_busy s=%0d got=%0b want=%0b", s, busy, exp_busy()); end
         checks++;
         if (filt_active !== exp_active()) begin errors++; $display("[TB] FAIL startup_active s=%0d got=%0b want=%0b", s, filt_active, exp_active()); end
         checks++;
         if (filt_reset !== exp_freset()) begin errors++; $display("[TB] FAIL startup_filt_reset s=%0d got=%0b want=%0b", s, filt_reset, exp_freset()); end
         checks++;
         if (filt_i_in !== exp_fin(ri)) begin errors++; $display("[TB] FAIL startup_filt_i_in s=%0d got=%h want=%h", s, filt_i_in, exp_fin(ri)); end
         checks++;
         if (i_out !== m_out_i || q_out !== m_out_q) begin
            errors++; $display("[TB] FAIL startup_out s=%0d got=%h/%h want=%h/%h", s, i_out, q_out, m_out_i, m_out_q);
         end
         if (busy === 1'b1) busy_count++;
         if (filt_active === 1'b1 && first_active == 0) first_active = s;
      end
      checks++;
      if (busy_count != F + S) begin errors++; $display("[TB] FAIL startup_busy_len got=%0d want=%0d", busy_count, F + S); end
      checks++;
      if (first_active != F + S + 1) begin errors++; $display("[TB] FAIL startup_active_clock got=%0d want=%0d", first_active, F + S + 1); end
   endtask

   task automatic test_switchover();
      logic [BW-1:0] ri [17];
      logic [BW-1:0] rq [17];
      for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      for (int s = 1; s <= 16; s++) begin
         ri[s] = 16'($urandom);
         rq[s] = 16'($urandom);
         applyStimulus(1'b0, 1'b1, 1'b0, ri[s], rq[s]);
         checks++;
         if (i_out !== m_out_i || q_out !== m_out_q) begin
            errors++; $display("[TB] FAIL switch_out s=%0d got=%h/%h want=%h/%h", s, i_out, q_out, m_out_i, m_out_q);
         end
         if (s == F + S + 1) begin
            checks++;
            if (i_out !== ri[s-1] || q_out !== rq[s-1]) begin
               errors++; $display("[TB] FAIL switch_last_raw got=%h/%h want=%h/%h", i_out, q_out, ri[s-1], rq[s-1]);
            end
         end
         if (s == F + S + 2) begin
            checks++;
            if (i_out !== ri[s-1] + OFFS || q_out !== rq[s-1] + OFFS) begin
               errors++; $display("[TB] FAIL switch_first_filt got=%h/%h want=%h/%h", i_out, q_out, ri[s-1] + OFFS, rq[s-1] + OFFS);
            end
         end
      end
   endtask

   task automatic test_restart();
      int busy_count = 0;
      for (int s = 0; s < 15; s++) begin
         applyStimulus(1'b0, 1'b1, (s == 0), 16'($urandom), 16'($urandom));
         checks++;
         if (busy !== exp_busy() || filt_active !== exp_active()) begin
            errors++; $display("[TB] FAIL restart_status s=%0d got=%0b%0b want=%0b%0b", s, busy, filt_active, exp_busy(), exp_active());
         end
         if (busy === 1'b1) busy_count++;
      end
      checks++;
      if (busy_count != F + S) begin errors++; $display("[TB] FAIL restart_busy_len got=%0d want=%0d", busy_count, F + S); end
      checks++;
      if (filt_active !== 1'b1) begin errors++; $display("[TB] FAIL restart_back_to_run got=%0b want=1", filt_active); end
   endtask

   task automatic test_abort();
      int busy_count = 0;
      for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      for (int k = 0; k < F + 2; k++) applyStimulus(1'b0, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_settle got=%0b want=1", busy); end
      applyStimulus(1'b0, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
      checks++;
      if (filt_reset !== 1'b1 || busy !== 1'b0 || filt_active !== 1'b0) begin
         errors++; $display("[TB] FAIL abort_priority got=%0b%0b%0b want=100", filt_reset, busy, filt_active);
      end
      for (int s = 0; s < F + S + 2; s++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
         if (busy === 1'b1) busy_count++;
      end
      checks++;
      if (busy_count != F + S) begin errors++; $display("[TB] FAIL abort_rerun_len got=%0d want=%0d", busy_count, F + S); end
      checks++;
      if (i_out !== m_out_i) begin errors++; $display("[TB] FAIL abort_out got=%h want=%h", i_out, m_out_i); end
   endtask

   task automatic test_midreset();
      int busy_count = 0;
      int zero_count = 0;
      logic [BW-1:0] ri;
      applyStimulus(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
      applyStimulus(1'b1, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
      checks++;
      if (busy !== 1'b0 || filt_reset !== 1'b1 || i_out !== 16'h0 || q_out !== 16'h0) begin
         errors++; $display("[TB] FAIL midreset_state busy=%0b filt_reset=%0b out=%h/%h want 0/1/0000/0000", busy, filt_reset, i_out, q_out);
      end
      for (int s = 0; s < F + S + 2; s++) begin
         ri = 16'($urandom) | 16'h0001;
         applyStimulus(1'b0, 1'b1, 1'b0, ri, 16'($urandom));
         if (busy === 1'b1) busy_count++;
         if (busy === 1'b1 && filt_i_in === 16'h0) zero_count++;
         checks++;
         if (i_out !== m_out_i || q_out !== m_out_q) begin
            errors++; $display("[TB] FAIL midreset_out s=%0d got=%h/%h want=%h/%h", s, i_out, q_out, m_out_i, m_out_q);
         end
      end
      checks++;
      if (busy_count != F + S) begin errors++; $display("[TB] FAIL midreset_busy_len got=%0d want=%0d", busy_count, F + S); end
      checks++;
      if (zero_count != F) begin errors++; $display("[TB] FAIL midreset_flush_len got=%0d want=%0d", zero_count, F); end
   endtask

   task automatic test_random();
      logic [BW-1:0] ri;
      logic [BW-1:0] rq;
      logic rst;
      logic en;
      logic rs;
      for (int s = 0; s < 400; s++) begin
         ri  = 16'($urandom);
         rq  = 16'($urandom);
         rst = ($urandom_range(0, 99) == 0);
         en  = ($urandom_range(0, 39) != 0);
         rs  = ($urandom_range(0, 29) == 0);
         applyStimulus(rst, en, rs, ri, rq);
         checks++;
         if (busy !== exp_busy() || filt_active !== exp_active() || filt_reset !== exp_freset()) begin
            errors++;
            $display("[TB] FAIL random_status s=%0d got=%0b%0b%0b want=%0b%0b%0b", s, busy, filt_active, filt_reset,
                     exp_busy(), exp_active(), exp_freset());
         end
         checks++;
         if (i_out !== m_out_i || q_out !== m_out_q) begin
            errors++; $display("[TB] FAIL random_out s=%0d got=%h/%h want=%h/%h", s, i_out, q_out, m_out_i, m_out_q);
         end
         if (m_phase() != 0) begin
            checks++;
            if (filt_i_in !== exp_fin(ri) || filt_q_in !== exp_fin(rq)) begin
               errors++; $display("[TB] FAIL random_filt_in s=%0d got=%h/%h want=%h/%h", s, filt_i_in, filt_q_in, exp_fin(ri), exp_fin(rq));
            end
         end
      end
   endtask

   // Test sequence
   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      enable_req = 1'b0;
      restart    = 1'b0;
      i_raw      = '0;
      q_raw      = '0;
      i_filt     = '0;
      q_filt     = '0;
      prev_i     = '0;
      prev_q     = '0;
      m_active   = 1'b0;
      m_t        = 0;
      m_raw_i    = '0;
      m_raw_q    = '0;
      m_out_i    = '0;
      m_out_q    = '0;
      test_reset();
      test_bypass_latency();
      test_startup();
      test_switchover();
      test_restart();
      test_abort();
      test_midreset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
